// File: rtl/k005297_pkg.sv
`default_nettype none
// ============================================================================
// k005297_pkg
// Shared encodings for the K005297 bubble-memory command register block.
// Revision: 1.0
// ============================================================================
package k005297_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CMD     = 2'd0;
  localparam logic [1:0] ADDR_PAGE_LO = 2'd1;
  localparam logic [1:0] ADDR_PAGE_HI = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_ACCEPTED = 1;
  localparam int STAT_DONE     = 2;
  localparam int STAT_ERR      = 3;
  localparam int STAT_ILLEGAL  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CMD_RD    = 0;
  localparam int CMD_WR    = 1;
  localparam int CMD_ABORT = 7;

  typedef struct packed {
    logic overrun;
    logic illegal;
    logic err;
    logic done;
  } flags_t;

  function automatic logic [7:0] status_byte(input state_e st, input flags_t f);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_BUSY]     = (st != ST_IDLE);
    s[STAT_ACCEPTED] = (st == ST_ACTIVE);
    s[STAT_DONE]     = f.done;
    s[STAT_ERR]      = f.err;
    s[STAT_ILLEGAL]  = f.illegal;
    s[STAT_OVERRUN]  = f.overrun;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/k005297_strobe_sync.sv
`default_nettype none
// ============================================================================
// k005297_strobe_sync
// Two-flop synchronizer for an active-low CPU strobe with rising-edge detect.
// Revision: 1.0
// ============================================================================
module k005297_strobe_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_n_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle level of an active-low strobe is 1, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= strobe_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/k005297_cmdreg.sv
`default_nettype none
// ============================================================================
// k005297_cmdreg
// CPU-facing command/page/status register and request FSM of the K005297.
// Revision: 1.0
// ============================================================================
module k005297_cmdreg
  import k005297_pkg::*;
#(
  parameter int PAGE_W = 12
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic              i_CLK2M_PCEN_n,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_WR_n,
  input  logic              i_CPU_RD_n,
  input  logic [1:0]        i_CPU_ADDR,
  input  logic [7:0]        i_CPU_DIN,
  output logic [7:0]        o_CPU_DOUT,
  input  logic              i_CMDREG_RST_n,
  input  logic              i_CMD_ACCEPTED_n,
  input  logic              i_FSMERR_RESTART_n,
  output logic              o_CMDREG_RDREQ,
  output logic              o_CMDREG_WRREQ,
  output logic [PAGE_W-1:0] o_PAGE_NUM,
  output logic              o_IRQ
);

  localparam int HI_W = PAGE_W - 8;

  logic              wr_sync, wr_rise;
  logic              rd_sync, rd_rise;
  logic [1:0]        hold_addr_q;
  logic [7:0]        hold_data_q;
  logic [1:0]        rd_addr_q;
  state_e            state_q;
  logic              rdreq_q, wrreq_q;
  logic [PAGE_W-1:0] page_q;
  flags_t            flags_q;
  logic              irq_q;

  k005297_strobe_sync u_wr_sync (
    .clk_i      (i_MCLK),
    .rst_i      (i_RST),
    .strobe_n_i (i_CPU_CS_n | i_CPU_WR_n),
    .sync_o     (wr_sync),
    .rise_o     (wr_rise)
  );

  k005297_strobe_sync u_rd_sync (
    .clk_i      (i_MCLK),
    .rst_i      (i_RST),
    .strobe_n_i (i_CPU_CS_n | i_CPU_RD_n),
    .sync_o     (rd_sync),
    .rise_o     (rd_rise)
  );

  logic fsm_en, busy;
  logic err_ev, done_ev, acc_ev, fsm_ev;
  logic cmd_wr, page_wr, status_rd;
  logic cmd_rd_bit, cmd_wr_bit, cmd_abort;

  assign fsm_en     = ~i_CLK2M_PCEN_n;
  assign busy       = (state_q != ST_IDLE);
  assign err_ev     = fsm_en & ~i_FSMERR_RESTART_n;
  assign done_ev    = fsm_en & ~i_CMDREG_RST_n & busy;
  assign acc_ev     = fsm_en & ~i_CMD_ACCEPTED_n & (state_q == ST_REQ);
  assign fsm_ev     = err_ev | done_ev | acc_ev;
  assign cmd_wr     = wr_rise & (hold_addr_q == ADDR_CMD);
  assign page_wr    = wr_rise & ((hold_addr_q == ADDR_PAGE_LO) | (hold_addr_q == ADDR_PAGE_HI));
  assign status_rd  = rd_rise & (rd_addr_q == ADDR_STATUS);
  assign cmd_rd_bit = hold_data_q[CMD_RD];
  assign cmd_wr_bit = hold_data_q[CMD_WR];
  assign cmd_abort  = hold_data_q[CMD_ABORT];

  // Later assignments in this block override earlier ones, so flags set in
  // the same cycle as a status-read clear survive.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      rdreq_q     <= 1'b0;
      wrreq_q     <= 1'b0;
      page_q      <= '0;
      flags_q     <= '0;
      irq_q       <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      if (!wr_sync) begin
        hold_addr_q <= i_CPU_ADDR;
        hold_data_q <= i_CPU_DIN;
      end
      if (!rd_sync) begin
        rd_addr_q <= i_CPU_ADDR;
      end

      if (status_rd) begin
        flags_q <= '0;
        irq_q   <= 1'b0;
      end

      if (err_ev) begin
        state_q     <= ST_IDLE;
        rdreq_q     <= 1'b0;
        wrreq_q     <= 1'b0;
        flags_q.err <= 1'b1;
        irq_q       <= 1'b1;
      end else if (done_ev) begin
        state_q      <= ST_IDLE;
        rdreq_q      <= 1'b0;
        wrreq_q      <= 1'b0;
        flags_q.done <= 1'b1;
        irq_q        <= 1'b1;
      end else if (acc_ev) begin
        state_q <= ST_ACTIVE;
      end else if (cmd_wr) begin
        if (busy) begin
          if (cmd_abort) begin
            state_q <= ST_IDLE;
            rdreq_q <= 1'b0;
            wrreq_q <= 1'b0;
          end else begin
            flags_q.overrun <= 1'b1;
          end
        end else if (!cmd_abort && (cmd_rd_bit ^ cmd_wr_bit)) begin
          state_q <= ST_REQ;
          rdreq_q <= cmd_rd_bit;
          wrreq_q <= cmd_wr_bit;
        end else if (!cmd_abort && cmd_rd_bit && cmd_wr_bit) begin
          flags_q.illegal <= 1'b1;
          irq_q           <= 1'b1;
        end
      end

      if (cmd_wr && fsm_ev) begin
        flags_q.overrun <= 1'b1;
      end

      if (page_wr) begin
        if (busy) begin
          flags_q.overrun <= 1'b1;
        end else if (hold_addr_q == ADDR_PAGE_LO) begin
          page_q[7:0] <= hold_data_q;
        end else begin
          page_q[PAGE_W-1:8] <= hold_data_q[HI_W-1:0];
        end
      end
    end
  end

  always_comb begin
    o_CPU_DOUT = 8'h00;
    if (!i_CPU_CS_n && !i_CPU_RD_n) begin
      case (i_CPU_ADDR)
        ADDR_CMD:     o_CPU_DOUT = {6'b0, wrreq_q, rdreq_q};
        ADDR_PAGE_LO: o_CPU_DOUT = page_q[7:0];
        ADDR_PAGE_HI: o_CPU_DOUT = 8'(page_q[PAGE_W-1:8]);
        default:      o_CPU_DOUT = status_byte(state_q, flags_q);
      endcase
    end
  end

  // Requests drop combinationally with reset so a reset never leaves a stray request.
  assign o_CMDREG_RDREQ = rdreq_q & ~i_RST;
  assign o_CMDREG_WRREQ = wrreq_q & ~i_RST;
  assign o_PAGE_NUM     = page_q;
  assign o_IRQ          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_k005297_cmdreg.sv
`default_nettype none
// ============================================================================
// tb_k005297_cmdreg
// Scoreboard bench for the K005297 command register block.
// Revision: 1.0
// ============================================================================
module tb_k005297_cmdreg;

  localparam int PAGE_W = 12;

  logic              clk = 1'b0;
  logic              rst, pcen_n, cs_n, wr_n, rd_n;
  logic [1:0]        addr;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              cmdrst_n, acc_n, err_n;
  logic              rdreq, wrreq, irq;
  logic [PAGE_W-1:0] page;

  k005297_cmdreg #(.PAGE_W(PAGE_W)) dut (
    .i_MCLK             (clk),
    .i_RST              (rst),
    .i_CLK2M_PCEN_n     (pcen_n),
    .i_CPU_CS_n         (cs_n),
    .i_CPU_WR_n         (wr_n),
    .i_CPU_RD_n         (rd_n),
    .i_CPU_ADDR         (addr),
    .i_CPU_DIN          (din),
    .o_CPU_DOUT         (dout),
    .i_CMDREG_RST_n     (cmdrst_n),
    .i_CMD_ACCEPTED_n   (acc_n),
    .i_FSMERR_RESTART_n (err_n),
    .o_CMDREG_RDREQ     (rdreq),
    .o_CMDREG_WRREQ     (wrreq),
    .o_PAGE_NUM         (page),
    .o_IRQ              (irq)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] obs, ev;
  string       nm;
  logic [7:0]  rdat;

  task automatic push(input string n, input logic [15:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic cpu_write_nowait(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; addr = a; din = d; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    cpu_write_nowait(a, d);
    repeat (3) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    #1 d = dout;
    repeat (3) @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Strobe held low for less than half a cycle: no rising MCLK edge sees it.
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    #1 d = dout;
    rd_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic fsm_pulse(input int which);
    @(negedge clk);
    case (which)
      0:       acc_n    = 1'b0;
      1:       cmdrst_n = 1'b0;
      default: err_n    = 1'b0;
    endcase
    @(negedge clk);
    acc_n = 1'b1; cmdrst_n = 1'b1; err_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push("rst_rdreq", 16'h0); push("rst_wrreq", 16'h0); push("rst_irq", 16'h0);
    push("rst_page", 16'h0); push("rst_dout_idle", 16'h0); push("rst_status", 16'h00);
    push("rst_dout_rdhigh", 16'h0);
    @(negedge clk);
    #1;
    obs = 16'(rdreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(wrreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);   ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(page);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(dout);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd3;
    #1 obs = 16'(dout);
    cs_n = 1'b1;
    ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_read_request();
    cpu_write(2'd1, 8'hA5);
    cpu_write(2'd2, 8'h03);
    push("req_rdreq_2clk", 16'h0); push("req_rdreq_3clk", 16'h1); push("req_wrreq", 16'h0);
    push("req_page", 16'h3A5); push("req_status", 16'h01); push("req_cmd_readback", 16'h01);
    cpu_write_nowait(2'd0, 8'h01);
    repeat (2) @(negedge clk);
    #1 obs = 16'(rdreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    @(negedge clk);
    #1 obs = 16'(rdreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(wrreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(page);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd0, rdat);
    obs = 16'(rdat);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_accept_done();
    push("acc_status", 16'h03); push("acc_irq", 16'h0);
    push("done_rdreq", 16'h0); push("done_status", 16'h04); push("done_irq", 16'h1);
    push("done_read_data", 16'h04); push("clr_status", 16'h00); push("clr_irq", 16'h0);
    fsm_pulse(0);
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    fsm_pulse(1);
    #1 obs = 16'(rdreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_illegal();
    push("ill_reqs", 16'h0); push("ill_status", 16'h10); push("ill_irq", 16'h1);
    push("ill_read_data", 16'h10); push("ill_clr_status", 16'h00);
    cpu_write(2'd0, 8'h03);
    #1 obs = {14'b0, wrreq, rdreq}; ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_overrun_abort();
    push("ovr_reqs", 16'h1); push("ovr_status", 16'h23); push("ovr_page_kept", 16'h3A5);
    push("abort_status", 16'h20); push("abort_reqs", 16'h0); push("abort_read_data", 16'h20);
    cpu_write(2'd0, 8'h01);
    fsm_pulse(0);
    cpu_write(2'd0, 8'h02);
    #1 obs = {14'b0, wrreq, rdreq}; ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_write(2'd1, 8'h55);
    #1 obs = 16'(page); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_write(2'd0, 8'h80);
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = {14'b0, wrreq, rdreq}; ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_coincident();
    push("coin_status", 16'h24); push("coin_reqs", 16'h0); push("coin_irq", 16'h1);
    cpu_write(2'd0, 8'h01);
    cpu_write_nowait(2'd0, 8'h02);
    repeat (2) @(negedge clk);
    cmdrst_n = 1'b0;
    @(negedge clk);
    cmdrst_n = 1'b1;
    @(negedge clk);
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = {14'b0, wrreq, rdreq}; ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
  endtask

  task automatic test_error();
    push("err_idle_status", 16'h08); push("err_idle_irq", 16'h1);
    push("err_req_wrreq", 16'h0); push("err_req_status", 16'h08);
    fsm_pulse(2);
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
    cpu_write(2'd0, 8'h02);
    fsm_pulse(2);
    #1 obs = 16'(wrreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
  endtask

  task automatic test_pcen_gate();
    push("pcen_status", 16'h01); push("pcen_abort_status", 16'h00); push("pcen_abort_wrreq", 16'h0);
    cpu_write(2'd0, 8'h02);
    pcen_n = 1'b1;
    fsm_pulse(0);
    pcen_n = 1'b0;
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_write(2'd0, 8'h80);
    peek(2'd3, rdat);
    obs = 16'(rdat);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(wrreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  task automatic test_back_to_back();
    push("b2b_rdreq", 16'h1); push("b2b_read_data", 16'h05); push("b2b_after_clr", 16'h01);
    cpu_write(2'd0, 8'h02);
    fsm_pulse(0);
    fsm_pulse(1);
    cpu_write(2'd0, 8'h01);
    #1 obs = 16'(rdreq); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_read(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    cpu_write(2'd0, 8'h80);
  endtask

  task automatic test_reset_mid();
    push("rstmid_reqs", 16'h0); push("rstmid_status", 16'h00);
    push("rstmid_page", 16'h0); push("rstmid_irq", 16'h0);
    cpu_write(2'd0, 8'h01);
    fsm_pulse(0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 obs = {14'b0, wrreq, rdreq}; ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    rst = 1'b0;
    peek(2'd3, rdat);
    obs = 16'(rdat); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(page); ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
    obs = 16'(irq);  ev = exp_q.pop_front(); nm = name_q.pop_front(); total++; if (obs !== ev) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", nm, obs, ev); end
  endtask

  initial begin
    rst = 1'b1; pcen_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    addr = 2'd0; din = 8'h00; cmdrst_n = 1'b1; acc_n = 1'b1; err_n = 1'b1;
    test_reset();
    test_read_request();
    test_accept_done();
    test_illegal();
    test_overrun_abort();
    test_coincident();
    test_error();
    test_pcen_gate();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
